// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that turns a byte stream into 32-bit
// instruction-memory writes. It keeps the core in reset until a full image
// with a matching XOR checksum has been received.
module imem_loader #(
  parameter int DEPTH = 64,
  parameter int IDX_W = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [63:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_reset,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK,
    S_RUN,
    S_ERROR
  } state_t;

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  // Reset synchroniser: assertion passes straight through, release is
  // delayed by two clock edges so all state leaves reset on the same edge.
  logic [1:0] rst_sync_q;
  logic [1:0] rst_sync_d;
  logic       rst_n_int;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_n_int  = rst_sync_q[1];

  // Two-stage synchroniser register for the reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= rst_sync_d;
  end

  state_t            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       len_q, len_d;
  logic [IDX_W-1:0]  word_idx_q, word_idx_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [7:0]        csum_q, csum_d;
  logic [23:0]       asm_q, asm_d;      // low three bytes of the word in flight
  logic              we_q, we_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              accept;
  logic [15:0]       len_n;
  logic              last_word;

  assign byte_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                      (state_q == S_DATA)   || (state_q == S_CHECK);
  assign accept     = byte_valid && byte_ready;
  assign len_n      = {byte_data, len_lo_q};
  assign last_word  = ({{(16-IDX_W){1'b0}}, word_idx_q} == (len_q - 16'd1));

  // Next-state logic: stream parsing, word assembly and checksum tracking.
  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    csum_d     = csum_q;
    asm_d      = asm_q;
    we_d       = 1'b0;
    wr_idx_d   = wr_idx_q;
    wdata_d    = wdata_q;

    case (state_q)
      S_IDLE, S_RUN, S_ERROR: begin
        if (start) begin
          state_d    = S_LEN_LO;
          word_idx_d = '0;
          byte_cnt_d = 2'd0;
          csum_d     = 8'h00;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_lo_d = byte_data;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d = len_n;
          if (len_n == 16'd0 || len_n > DEPTH_W) state_d = S_ERROR;
          else                                   state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          csum_d     = csum_q ^ byte_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: asm_d[7:0]   = byte_data;
            2'd1: asm_d[15:8]  = byte_data;
            2'd2: asm_d[23:16] = byte_data;
            default: begin
              // Fourth byte completes the word; the write goes out next cycle.
              we_d       = 1'b1;
              wdata_d    = {byte_data, asm_q};
              wr_idx_d   = word_idx_q;
              word_idx_d = word_idx_q + IDX_W'(1);
              if (last_word) state_d = S_CHECK;
            end
          endcase
        end
      end
      S_CHECK: begin
        if (accept) begin
          if (byte_data == csum_q) state_d = S_RUN;
          else                     state_d = S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared by the synchronised reset.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q    <= S_IDLE;
      len_lo_q   <= 8'h00;
      len_q      <= 16'h0000;
      word_idx_q <= '0;
      byte_cnt_q <= 2'd0;
      csum_q     <= 8'h00;
      asm_q      <= 24'h000000;
      we_q       <= 1'b0;
      wr_idx_q   <= '0;
      wdata_q    <= 32'h00000000;
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      byte_cnt_q <= byte_cnt_d;
      csum_q     <= csum_d;
      asm_q      <= asm_d;
      we_q       <= we_d;
      wr_idx_q   <= wr_idx_d;
      wdata_q    <= wdata_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = {{(62-IDX_W){1'b0}}, wr_idx_q, 2'b00};
  assign imem_wdata = wdata_q;
  assign core_reset = (state_q != S_RUN);
  assign done       = (state_q == S_RUN);
  assign error      = (state_q == S_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of the instruction-memory loader.
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [63:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_reset;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [7:0]  stream[$];
  logic [31:0] exp_data[$];
  logic [63:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  imem_loader #(.DEPTH(64), .IDX_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every write strobe on the falling edge, one line per write.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
      $display("write addr %0h data %08h", imem_addr, imem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drive the current stream; optional idle gaps; start raised with byte start_idx.
  task automatic send_stream(input int gap_max, input int start_idx);
    int n;
    for (int i = 0; i < stream.size(); i++) begin
      if (gap_max > 0) begin
        n = $urandom_range(0, gap_max);
        repeat (n) begin
          @(negedge clk);
          byte_valid = 1'b0;
          start      = 1'b0;
        end
      end
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = stream[i];
      start      = (i == start_idx);
      chk("byte_ready", byte_ready, 1'b1);
      @(posedge clk);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic check_writes();
    chk("n_writes", 64'(wr_addr_q.size()), 64'(exp_data.size()));
    for (int i = 0; i < exp_data.size() && i < wr_addr_q.size(); i++) begin
      chk($sformatf("waddr%0d", i), wr_addr_q[i], 64'(i * 4));
      chk($sformatf("wdata%0d", i), 64'(wr_data_q[i]), 64'(exp_data[i]));
    end
  endtask

  task automatic clear_writes();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic cr);
    chk({tag, "_done"}, done, d);
    chk({tag, "_error"}, error, e);
    chk({tag, "_core_reset"}, core_reset, cr);
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  cs;
    reset      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;

    // Reset values, during reset and after synchronised release.
    repeat (3) @(negedge clk);
    chk("rst_byte_ready", byte_ready, 1'b0);
    chk("rst_we", imem_we, 1'b0);
    chk("rst_addr", imem_addr, 64'h0);
    chk("rst_wdata", imem_wdata, 32'h0);
    check_status("rst", 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_byte_ready", byte_ready, 1'b0);
    check_status("idle", 1'b0, 1'b0, 1'b1);

    // Good load, N=2.
    $display("load: good N=2");
    clear_writes();
    stream   = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hC1};
    exp_data = '{32'h00500093, 32'h00100113};
    pulse_start();
    send_stream(0, -1);
    check_status("good", 1'b1, 1'b0, 1'b0);
    check_writes();

    // Bad checksum, restarted from RUN.
    $display("load: bad checksum");
    clear_writes();
    pulse_start();
    check_status("restart", 1'b0, 1'b0, 1'b1);
    stream[10] = 8'hC0;
    send_stream(0, -1);
    check_status("badcs", 1'b0, 1'b1, 1'b1);
    check_writes();

    // Bad length N=0, restarted from ERROR.
    $display("load: length 0");
    clear_writes();
    exp_data.delete();
    pulse_start();
    chk("err_cleared", error, 1'b0);
    stream = '{8'h00, 8'h00};
    send_stream(0, -1);
    check_status("len0", 1'b0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    check_writes();

    // Bad length N=65.
    $display("load: length 65");
    clear_writes();
    pulse_start();
    stream = '{8'h41, 8'h00};
    send_stream(0, -1);
    check_status("len65", 1'b0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    check_writes();

    // Largest image, N=64.
    $display("load: N=64");
    clear_writes();
    stream   = '{8'h40, 8'h00};
    exp_data.delete();
    cs = 8'h00;
    for (int i = 0; i < 64; i++) begin
      w = {8'hA5, 8'(i * 3), 8'(i), 8'(255 - i)};
      exp_data.push_back(w);
      for (int b = 0; b < 4; b++) begin
        stream.push_back(w[8*b +: 8]);
        cs = cs ^ w[8*b +: 8];
      end
    end
    stream.push_back(cs);
    pulse_start();
    send_stream(0, -1);
    check_status("n64", 1'b1, 1'b0, 1'b0);
    check_writes();

    // Reset mid-load after five payload bytes.
    $display("load: reset mid-load");
    clear_writes();
    pulse_start();
    stream = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13};
    send_stream(0, -1);
    chk("pre_rst_wdata", imem_wdata, 32'h00500093);
    clear_writes();
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_byte_ready", byte_ready, 1'b0);
    chk("mid_rst_we", imem_we, 1'b0);
    chk("mid_rst_addr", imem_addr, 64'h0);
    chk("mid_rst_wdata", imem_wdata, 32'h0);
    check_status("mid_rst", 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_rst_no_writes", 64'(wr_addr_q.size()), 64'd0);
    stream   = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hC1};
    exp_data = '{32'h00500093, 32'h00100113};
    pulse_start();
    send_stream(0, -1);
    check_status("after_rst", 1'b1, 1'b0, 1'b0);
    check_writes();

    // Gapped stream, then restart from RUN with a one-word image.
    $display("load: gapped N=2");
    clear_writes();
    pulse_start();
    send_stream(2, -1);
    check_status("gapped", 1'b1, 1'b0, 1'b0);
    check_writes();
    $display("load: restart N=1");
    clear_writes();
    pulse_start();
    check_status("restart2", 1'b0, 1'b0, 1'b1);
    stream   = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    exp_data = '{32'h12345678};
    send_stream(0, -1);
    check_status("n1", 1'b1, 1'b0, 1'b0);
    check_writes();

    // Start pulsed during DATA is ignored.
    $display("load: start during DATA");
    clear_writes();
    pulse_start();
    stream   = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hC1};
    exp_data = '{32'h00500093, 32'h00100113};
    send_stream(0, 4);
    check_status("ign_start", 1'b1, 1'b0, 1'b0);
    check_writes();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory loader that sits directly upstream of the single-cycle RV64 core. It accepts a byte stream (from a UART receiver or test host), assembles little-endian 32-bit instruction words, and writes them into the instruction memory's write port. It holds the core in reset until a complete, checksum-verified image is loaded, then releases it.

## Interface
Parameters:
- DEPTH, 64, instruction-memory capacity in 32-bit words; legal image length is 1..DEPTH.
- IDX_W, 6, word-index width; must satisfy 2^IDX_W >= DEPTH.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load from IDLE, RUN or ERROR.
- byte_valid  in  1  byte_data holds a valid byte this cycle.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  64  byte address of the word being written (word_idx*4).
- imem_wdata  out  32  assembled instruction word.
- core_reset  out  1  active-high reset to the core; 1 = core held.
- done  out  1  image loaded and verified; core running.
- error  out  1  load failed; core remains held.

## Operation
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N*4 payload bytes (each word least-significant byte first), then one checksum byte = XOR of all payload bytes only (length bytes excluded).
- Handshake: a byte transfers on a rising edge where byte_valid & byte_ready. byte_ready = 1 in LEN_LO, LEN_HI, DATA, CHECK; 0 in IDLE, RUN, ERROR. No backpressure inside a load.
- States: IDLE, LEN_LO, LEN_HI, DATA, CHECK, RUN, ERROR.
- IDLE: start -> LEN_LO; clears word_idx, byte counter, checksum, done, error.
- LEN_LO: byte accepted -> LEN_HI.
- LEN_HI: byte accepted -> if N == 0 or N > DEPTH -> ERROR; else DATA.
- DATA: each byte shifts into bits [8k+7:8k] of the assembly register (k = 0..3) and XORs into the checksum. On the 4th byte: registered write issued next cycle, word_idx increments; after word N -> CHECK.
- CHECK: byte accepted -> equal to running XOR -> RUN, else ERROR.
- RUN: core_reset = 0, done = 1. start -> LEN_LO (core_reset reasserted, done cleared).
- ERROR: core_reset = 1, error = 1. start -> LEN_LO (error cleared).
- start in LEN_LO, LEN_HI, DATA or CHECK is ignored.
- Words already written before an error are not erased.

## Timing
- Reset values: byte_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, core_reset 1, done 0, error 0; state IDLE.
- reset assertion mid-load aborts immediately (asynchronous); core_reset returns to 1 with no further writes. Release is synchronised internally to clk.
- Write latency: imem_we high exactly one cycle, the cycle after the 4th byte of a word is accepted; imem_addr/imem_wdata valid in that same cycle, held until the next write.
- A byte accepted in the same cycle imem_we is high is handled normally (assembly register separate from imem_wdata).
- Error on bad length: ERROR entered the cycle after LEN_HI acceptance; no imem_we ever issued.
- CHECK -> RUN: core_reset falls and done rises the cycle after the checksum byte is accepted.
- Back-to-back bytes every cycle supported; minimum load = 2 + 4N + 1 accepted bytes.

## Test plan
- Good load, N=2: bytes 02 00 93 00 50 00 13 01 10 00 C1 -> writes 0x00500093 @0, 0x00100113 @4; done=1, core_reset=0, error=0.
- Bad checksum: same stream with final C0 -> two writes occur, error=1, core_reset stays 1, done=0.
- Bad length: 00 00, then separately 41 00 (N=65 > DEPTH) -> error=1 the cycle after LEN_HI, imem_we never asserted.
- Reset mid-load: drive reset low after 5 payload bytes -> outputs at reset values immediately; after release, start and full good load succeed from address 0.
- Gapped stream and restart: random byte_valid gaps during a good load -> identical writes; then start from RUN -> core_reset=1, done=0, new image reloads from address 0.
- Ignored start: pulse start during DATA -> no state change, load completes normally.
